// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the PC / fetch control slice.
// Imported by next_pc_calc and pc_fetch_ctrl.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } next_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select and redirect target arithmetic.
// Priority jr > jump > branch; targets are always word aligned.
import mips_pc_pkg::*;

module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_out,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_base,
  input  logic [15:0]       br_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output next_sel_e         sel,
  output logic [ADDR_W-1:0] target,
  output logic              jr_misaligned
);

  logic              is_jr;
  logic              is_j;
  logic              is_br;
  logic [ADDR_W-1:0] br_disp;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;

  assign pc_plus4 = pc_out + ADDR_W'(4);

  // One-hot after priority so the decoder below is truly unique
  assign is_jr = jr;
  assign is_j  = jump & ~jr;
  assign is_br = br_taken & ~jump & ~jr;

  assign br_disp = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
  assign br_tgt  = br_base + br_disp;
  assign j_tgt   = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};
  assign jr_tgt  = {jr_addr[ADDR_W-1:2], 2'b00};

  assign jr_misaligned = jr & (|jr_addr[1:0]);

  always_comb begin
    sel    = SEL_SEQ;
    target = pc_plus4;
    unique case (1'b1)
      is_jr: begin
        sel    = SEL_JR;
        target = jr_tgt;
      end
      is_j: begin
        sel    = SEL_J;
        target = j_tgt;
      end
      is_br: begin
        sel    = SEL_BR;
        target = {br_tgt[ADDR_W-1:2], 2'b00};
      end
      default: begin
        sel    = SEL_SEQ;
        target = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch FSM and pending-redirect tracking.
// One outstanding word request; redirects during a fetch squash it.
import mips_pc_pkg::*;

module pc_fetch_ctrl #(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_base,
  input  logic [15:0]       br_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misaligned
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]        state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  next_sel_e         sel;
  logic [ADDR_W-1:0] target;
  logic              jr_mis;
  logic              redirect;
  logic              squash;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc_out       (pc_out),
    .br_taken     (br_taken),
    .br_base      (br_base),
    .br_offset    (br_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .pc_plus4     (pc_plus4),
    .sel          (sel),
    .target       (target),
    .jr_misaligned(jr_mis)
  );

  assign redirect  = (sel != SEL_SEQ);
  assign squash    = pend_valid | redirect;
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc_out;
  assign if_valid  = imem_req & imem_ack & ~squash;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc_out      <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      misaligned  <= 1'b0;
    end else begin
      if (jr_mis)
        misaligned <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (redirect)
            pc_out <= target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (redirect)
              pc_out <= target;
            else if (pend_valid)
              pc_out <= pend_target;
            else
              pc_out <= pc_plus4;
            pend_valid <= 1'b0;
            state      <= stall ? S_HOLD : S_REQ;
          end else if (redirect) begin
            // Newest redirect wins over any earlier pending one
            pend_valid  <= 1'b1;
            pend_target <= target;
          end
        end
        S_HOLD: begin
          if (redirect)
            pc_out <= target;
          if (!stall)
            state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Vector-table bench for pc_fetch_ctrl with an expectation queue.
// Second instance exercises the PC wrap from the top of memory.
module tb_pc_fetch_ctrl;

  typedef struct {
    bit          st;
    bit          ak;
    bit          br;
    logic [31:0] bb;
    logic [15:0] bo;
    bit          j;
    logic [25:0] jt;
    bit          jrr;
    logic [31:0] ja;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    bit          em;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_base;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        if_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned;

  logic        w_rst_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ifv;
  logic [31:0] w_pc;
  logic [31:0] w_pp4;
  logic        w_mis;

  int pass_cnt = 0;
  int total    = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl u_dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_base    (br_base),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_target(jump_target),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .if_valid   (if_valid),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  pc_fetch_ctrl #(
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) u_wrap (
    .clk_in     (clk),
    .rst_n      (w_rst_n),
    .stall      (1'b0),
    .br_taken   (1'b0),
    .br_base    (32'h0),
    .br_offset  (16'h0),
    .jump       (1'b0),
    .jump_target(26'h0),
    .jr         (1'b0),
    .jr_addr    (32'h0),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_ack   (1'b1),
    .if_valid   (w_ifv),
    .pc_out     (w_pc),
    .pc_plus4   (w_pp4),
    .misaligned (w_mis)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(bit st, bit ak, bit br, logic [31:0] bb,
                              logic [15:0] bo, bit j, logic [25:0] jt,
                              bit jrr, logic [31:0] ja, bit er,
                              logic [31:0] ea, bit ev, bit em);
    vec_t v;
    v.st = st; v.ak = ak; v.br = br; v.bb = bb; v.bo = bo;
    v.j = j; v.jt = jt; v.jrr = jrr; v.ja = ja;
    v.er = er; v.ea = ea; v.ev = ev; v.em = em;
    return v;
  endfunction

  function automatic vec_t nv(bit ak, bit st, bit er, logic [31:0] ea,
                              bit ev, bit em);
    return mk(st, ak, 0, 0, 0, 0, 0, 0, 0, er, ea, ev, em);
  endfunction

  function automatic vec_t vj(bit ak, bit st, logic [25:0] jt, bit er,
                              logic [31:0] ea, bit ev, bit em);
    return mk(st, ak, 0, 0, 0, 1, jt, 0, 0, er, ea, ev, em);
  endfunction

  function automatic vec_t vjr(bit ak, logic [31:0] ja, bit er,
                               logic [31:0] ea, bit ev, bit em);
    return mk(0, ak, 0, 0, 0, 0, 0, 1, ja, er, ea, ev, em);
  endfunction

  function automatic vec_t vbr(bit ak, logic [31:0] bb, logic [15:0] bo,
                               bit er, logic [31:0] ea, bit ev, bit em);
    return mk(0, ak, 1, bb, bo, 0, 0, 0, 0, er, ea, ev, em);
  endfunction

  task automatic drive(input vec_t v);
    stall       = v.st;
    imem_ack    = v.ak;
    br_taken    = v.br;
    br_base     = v.bb;
    br_offset   = v.bo;
    jump        = v.j;
    jump_target = v.jt;
    jr          = v.jrr;
    jr_addr     = v.ja;
  endtask

  task automatic run_vecs(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("%s%0d req", tag, i), imem_req, e.er);
      chk($sformatf("%s%0d pc", tag, i), pc_out, e.ea);
      chk($sformatf("%s%0d pc4", tag, i), pc_plus4, e.ea + 32'd4);
      chk($sformatf("%s%0d ifv", tag, i), if_valid, e.ev);
      chk($sformatf("%s%0d mis", tag, i), misaligned, e.em);
      @(negedge clk);
    end
    vecs.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    w_rst_n = 1'b0;
    drive(nv(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst req", imem_req, 0);
    chk("rst pc", pc_out, 32'h0);
    chk("rst ifv", if_valid, 0);
    chk("rst mis", misaligned, 0);
    rst_n = 1'b1;

    // back-to-back fetches
    vecs.push_back(nv(1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h00, 1, 0));
    vecs.push_back(nv(1, 0, 1, 32'h04, 1, 0));
    vecs.push_back(nv(1, 0, 1, 32'h08, 1, 0));
    vecs.push_back(nv(1, 0, 1, 32'h0C, 1, 0));
    // jump during a 3-cycle wait
    vecs.push_back(vj(0, 0, 26'h40, 1, 32'h10, 0, 0));
    vecs.push_back(nv(0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(nv(0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h10, 0, 0));
    vecs.push_back(vjr(1, 32'h20, 1, 32'h100, 0, 0));
    // branch at ack, then jr beats jump
    vecs.push_back(vbr(1, 32'h24, 16'hFFFE, 1, 32'h20, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h1C, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 26'h40, 1, 32'h200,
                      1, 32'h20, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h200, 1, 0));
    vecs.push_back(vjr(1, 32'h30, 1, 32'h204, 0, 0));
    // stall during in-flight fetch
    vecs.push_back(nv(0, 1, 1, 32'h30, 0, 0));
    vecs.push_back(nv(1, 1, 1, 32'h30, 1, 0));
    vecs.push_back(nv(0, 1, 0, 32'h34, 0, 0));
    vecs.push_back(nv(1, 1, 0, 32'h34, 0, 0));
    vecs.push_back(nv(0, 0, 0, 32'h34, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h34, 1, 0));
    // redirect while held
    vecs.push_back(nv(1, 1, 1, 32'h38, 1, 0));
    vecs.push_back(vj(0, 1, 26'h50, 0, 32'h3C, 0, 0));
    vecs.push_back(nv(0, 0, 0, 32'h140, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h140, 1, 0));
    // misaligned jr is sticky
    vecs.push_back(vjr(1, 32'h103, 1, 32'h144, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h100, 1, 1));
    vecs.push_back(nv(1, 0, 1, 32'h104, 1, 1));
    // later pending redirect overwrites earlier
    vecs.push_back(vj(0, 0, 26'h10, 1, 32'h108, 0, 1));
    vecs.push_back(vbr(0, 32'h100, 16'h0004, 1, 32'h108, 0, 1));
    vecs.push_back(nv(1, 0, 1, 32'h108, 0, 1));
    vecs.push_back(nv(1, 0, 1, 32'h110, 1, 1));
    // redirect at ack beats pending
    vecs.push_back(vj(0, 0, 26'h10, 1, 32'h114, 0, 1));
    vecs.push_back(vbr(1, 32'h200, 16'h0001, 1, 32'h114, 0, 1));
    vecs.push_back(nv(1, 0, 1, 32'h204, 1, 1));
    vecs.push_back(vjr(1, 32'h50, 1, 32'h208, 0, 1));
    vecs.push_back(nv(0, 0, 1, 32'h50, 0, 1));
    run_vecs("a");

    // async reset in the middle of a handshake
    drive(nv(0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-rst req", imem_req, 1);
    chk("pre-rst pc", pc_out, 32'h50);
    rst_n = 1'b0;
    #1;
    chk("async req", imem_req, 0);
    chk("async pc", pc_out, 32'h0);
    chk("async mis", misaligned, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vecs.push_back(nv(1, 0, 0, 32'h0, 0, 0));
    vecs.push_back(nv(1, 0, 1, 32'h0, 1, 0));
    vecs.push_back(nv(1, 0, 1, 32'h4, 1, 0));
    run_vecs("b");

    // wrap from the top of the address space
    chk("w rst pc", w_pc, 32'hFFFF_FFFC);
    w_rst_n = 1'b1;
    #2;
    chk("w idle req", w_req, 0);
    chk("w pc4", w_pp4, 32'h0);
    @(negedge clk);
    #2;
    chk("w req1", w_req, 1);
    chk("w addr1", w_addr, 32'hFFFF_FFFC);
    chk("w ifv1", w_ifv, 1);
    @(negedge clk);
    #2;
    chk("w addr2", w_addr, 32'h0);
    chk("w ifv2", w_ifv, 1);
    chk("w mis", w_mis, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
